// File: rtl/instr_encoder.sv
// Immediate/instruction encoder with a one-beat skid buffer on a valid/ready stream.
// Optional range/alignment checking is enabled by defining INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] imm_sel,
  input  logic [31:0]      imm,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             out_err,
  output logic [7:0]       err_count
);

  localparam logic [SEL_W-1:0] SEL_I   = SEL_W'(3'd0);
  localparam logic [SEL_W-1:0] SEL_S   = SEL_W'(3'd1);
  localparam logic [SEL_W-1:0] SEL_B   = SEL_W'(3'd2);
  localparam logic [SEL_W-1:0] SEL_U   = SEL_W'(3'd3);
  localparam logic [SEL_W-1:0] SEL_J   = SEL_W'(3'd4);
  localparam logic [SEL_W-1:0] SEL_LUI = SEL_W'(3'd5);
  localparam logic [SEL_W-1:0] SEL_ISH = SEL_W'(3'd7);

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  // Flags immediates that would not survive a round trip through the decoder.
  function automatic logic range_err(input logic [SEL_W-1:0] sel, input logic [31:0] v);
    logic signed [31:0] sv;
    logic               e;
    sv = $signed(v);
    e  = 1'b0;
    case (sel)
      SEL_I, SEL_S:   e = (sv < -32'sd2048) || (sv > 32'sd2047);
      SEL_ISH:        e = (v[31:5] != 27'd0);
      SEL_B:          e = v[0] || (sv < -32'sd4096) || (sv > 32'sd4094);
      SEL_J:          e = v[0] || (sv < -32'sd1048576) || (sv > 32'sd1048574);
      SEL_U, SEL_LUI: e = (v[11:0] != 12'd0);
      default:        e = 1'b0;
    endcase
    return e;
  endfunction
`endif

  // Returns {err, instr}; unknown/reserved formats encode to zero and flag an error.
  function automatic logic [32:0] encode_beat(
    input logic [SEL_W-1:0] sel, input logic [31:0] v, input logic [6:0] op,
    input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
    input logic [2:0] f3, input logic [6:0] f7);
    logic [31:0] w;
    logic        e;
    w = 32'h0000_0000;
    e = 1'b0;
    case (sel)
      SEL_I:          w = {v[11:0], s1, f3, d, op};
      SEL_ISH:        w = {f7, v[4:0], s1, f3, d, op};
      SEL_S:          w = {v[11:5], s2, s1, f3, v[4:0], op};
      SEL_B:          w = {v[12], v[10:5], s2, s1, f3, v[4:1], v[11], op};
      SEL_U, SEL_LUI: w = {v[31:12], d, op};
      SEL_J:          w = {v[20], v[10:1], v[11], v[19:12], d, op};
      default: begin
        w = 32'h0000_0000;
        e = 1'b1;
      end
    endcase
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    e = e | range_err(sel, v);
`else
    e = e | 1'b0;
`endif
    return {e, w};
  endfunction

  logic        out_valid_r, out_err_r, skid_valid_r, skid_err_r, in_ready_r;
  logic [31:0] instr_r, skid_instr_r;
  logic [7:0]  err_count_r;
  logic [32:0] enc_s;
  logic        accept_s, out_free_s, skid_valid_nxt_s;

  assign enc_s      = encode_beat(imm_sel, imm, opcode, rd, rs1, rs2, funct3, funct7);
  assign accept_s   = in_valid && in_ready_r;
  assign out_free_s = !out_valid_r || out_ready;

  // Skid occupancy after this edge; in_ready is its registered complement.
  always_comb begin
    skid_valid_nxt_s = skid_valid_r;
    if (out_free_s) begin
      skid_valid_nxt_s = 1'b0;
    end else if (accept_s) begin
      skid_valid_nxt_s = 1'b1;
    end else begin
      skid_valid_nxt_s = skid_valid_r;
    end
  end

  // Output register and skid buffer; skid always drains ahead of new input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_err_r    <= 1'b0;
      instr_r      <= 32'h0000_0000;
      skid_valid_r <= 1'b0;
      skid_err_r   <= 1'b0;
      skid_instr_r <= 32'h0000_0000;
      in_ready_r   <= 1'b0;
    end else begin
      skid_valid_r <= skid_valid_nxt_s;
      in_ready_r   <= !skid_valid_nxt_s;
      if (out_free_s) begin
        if (skid_valid_r) begin
          out_valid_r <= 1'b1;
          instr_r     <= skid_instr_r;
          out_err_r   <= skid_err_r;
        end else if (accept_s) begin
          out_valid_r <= 1'b1;
          instr_r     <= enc_s[31:0];
          out_err_r   <= enc_s[32];
        end else begin
          out_valid_r <= 1'b0;
        end
      end else if (accept_s) begin
        skid_instr_r <= enc_s[31:0];
        skid_err_r   <= enc_s[32];
      end
    end
  end

  // Saturating count of errored beats at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_r <= 8'h00;
    end else if (accept_s && enc_s[32] && (err_count_r != 8'hFF)) begin
      err_count_r <= err_count_r + 8'd1;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign instr     = instr_r;
  assign out_err   = out_err_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: encodings, handshake/skid, error counting, reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  imm_sel = 3'd0;
  logic [31:0] imm = 32'h0;
  logic [6:0]  opcode = 7'h0;
  logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [6:0]  funct7 = 7'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] instr;
  logic        out_err;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  instr_encoder #(.SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm_sel(imm_sel), .imm(imm), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic set_beat(input logic [2:0] s, input logic [31:0] v, input logic [6:0] op,
                          input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                          input logic [2:0] f3, input logic [6:0] f7);
    imm_sel = s; imm = v; opcode = op; rd = d; rs1 = a; rs2 = b; funct3 = f3; funct7 = f7;
  endtask

  task automatic send_one(input logic [2:0] s, input logic [31:0] v, input logic [6:0] op,
                          input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                          input logic [2:0] f3, input logic [6:0] f7);
    set_beat(s, v, op, d, a, b, f3, f7);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 00000000", instr); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_err_count: got %h want 00", err_count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_i_type();
    out_ready = 1'b1;
    send_one(3'b000, 32'd5, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL i_valid: got %b want 1", out_valid); end
    checks++; if (instr !== 32'h00500093) begin errors++; $display("FAIL i_instr: got %h want 00500093", instr); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL i_err: got %b want 0", out_err); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL i_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_b_j();
    send_one(3'b010, 32'hFFFFFFFC, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0);
    checks++; if (instr !== 32'hFE000EE3) begin errors++; $display("FAIL b_instr: got %h want FE000EE3", instr); end
    send_one(3'b100, 32'd8, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0);
    checks++; if (instr !== 32'h008000EF) begin errors++; $display("FAIL j_instr: got %h want 008000EF", instr); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL j_err: got %b want 0", out_err); end
  endtask

  task automatic test_lui();
    logic exp_err;
    send_one(3'b101, 32'h12345000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0);
    checks++; if (instr !== 32'h123452B7) begin errors++; $display("FAIL lui_instr: got %h want 123452B7", instr); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL lui_err: got %b want 0", out_err); end
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    send_one(3'b101, 32'h12345001, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0);
    if (exp_err) exp_cnt++;
    checks++; if (instr !== 32'h123452B7) begin errors++; $display("FAIL lui_trunc_instr: got %h want 123452B7", instr); end
    checks++; if (out_err !== exp_err) begin errors++; $display("FAIL lui_range_err: got %b want %b", out_err, exp_err); end
    checks++; if (err_count !== 8'(exp_cnt)) begin errors++; $display("FAIL lui_err_count: got %0d want %0d", err_count, exp_cnt); end
  endtask

  task automatic test_formats();
    send_one(3'b001, 32'hFFFFFFF8, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'h0);
    checks++; if (instr !== 32'hFE312C23) begin errors++; $display("FAIL s_instr: got %h want FE312C23", instr); end
    send_one(3'b111, 32'd3, 7'h13, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20);
    checks++; if (instr !== 32'h40315093) begin errors++; $display("FAIL ishift_instr: got %h want 40315093", instr); end
    send_one(3'b011, 32'hABCDE000, 7'h17, 5'd10, 5'd0, 5'd0, 3'd0, 7'h0);
    checks++; if (instr !== 32'hABCDE517) begin errors++; $display("FAIL u_instr: got %h want ABCDE517", instr); end
  endtask

  task automatic test_reserved();
    send_one(3'b110, 32'h0000_0123, 7'h13, 5'd7, 5'd3, 5'd4, 3'd1, 7'h11);
    exp_cnt++;
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rsv_instr: got %h want 00000000", instr); end
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL rsv_err: got %b want 1", out_err); end
    checks++; if (err_count !== 8'(exp_cnt)) begin errors++; $display("FAIL rsv_err_count: got %0d want %0d", err_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    out_ready = 1'b0;
    set_beat(3'b000, 32'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_beat(3'b000, 32'd2, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0);
    @(posedge clk); #1;
    set_beat(3'b000, 32'd3, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bb_full_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (instr !== 32'h00100093 || out_valid !== 1'b1) begin errors++; $display("FAIL bb_hold: got %h/%b want 00100093/1", instr, out_valid); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (instr !== 32'h00200093 || in_ready !== 1'b1) begin errors++; $display("FAIL bb_second: got %h/%b want 00200093/1", instr, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (instr !== 32'h00300093 || out_valid !== 1'b1) begin errors++; $display("FAIL bb_third: got %h/%b want 00300093/1", instr, out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bb_no_dup: got %b want 0", out_valid); end
    // Streaming with out_ready high: each beat appears exactly one cycle after acceptance.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_beat(3'b000, 32'(i + 8), 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h0);
      @(posedge clk); #1;
      checks++;
      if (instr !== ({12'(i + 8), 20'h00113}) || out_valid !== 1'b1 || in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_%0d: got %h/%b/%b want %h/1/1", i, instr, out_valid, in_ready, {12'(i + 8), 20'h00113});
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_err_saturate();
    do_reset();
    out_ready = 1'b1;
    set_beat(3'b110, 32'h0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0);
    in_valid = 1'b1;
    repeat (254) @(posedge clk);
    #1;
    checks++; if (err_count !== 8'hFE) begin errors++; $display("FAIL sat_254: got %h want FE", err_count); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_256: got %h want FF", err_count); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_257: got %h want FF", err_count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send_one(3'b000, 32'd5, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0);
    send_one(3'b000, 32'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || err_count !== 8'h00) begin errors++; $display("FAIL mid_async: got %b/%h want 0/00", out_valid, err_count); end
    checks++; if (in_ready !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL mid_async_rdy: got %b/%h want 0/00000000", in_ready, instr); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_release: got %b/%b want 1/0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset();
    test_i_type();
    test_b_j();
    test_lui();
    test_formats();
    test_reserved();
    test_back_to_back();
    test_err_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
